// File: rtl/sandbox_host_link.sv
// sandbox_host_link: host-side UART framing link for the sandbox process.
//   RX: assembles A5-led 6-byte frames into control/inputData and holds them
//       with dataReceived until clearDR; times out partial frames.
//   TX: on a transmitData rise, serialises 5A/status/outputData (LSB first).
// Ports:
//   masterClock, reset (sync, active-low)
//   rxValid/rxByte            byte stream from the UART receiver
//   txReady/txValid/txByte    byte stream to the UART transmitter
//   dataReceived/control/inputData/clearDR   frame handshake with the process
//   transmitData/status/outputData/txBusy    reply request from the process
//   rxError/rxOverrun         1-cycle pulses for timeout and dropped bytes
module sandbox_host_link #(
  parameter logic [7:0] RX_SYNC        = 8'hA5,
  parameter logic [7:0] TX_SYNC        = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        txReady,
  output logic        txValid,
  output logic [7:0]  txByte,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        txBusy,
  output logic        rxError,
  output logic        rxOverrun
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {R_HUNT, R_CTRL, R_D0, R_D1, R_D2, R_D3, R_HOLD} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;
  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic [7:0]    control_q, control_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          rx_err_q, rx_err_d, rx_ovr_q, rx_ovr_d;
  logic [2:0]    idx_q, idx_d;
  logic [47:0]   frame_q, frame_d;
  logic          trans_q;
  logic [1:0]    lane;
  logic          rise;
  assign lane = 2'(rx_state_q - R_D0);
  assign rise = transmitData & ~trans_q;
  always_comb begin
    rx_state_d = rx_state_q;
    control_d  = control_q;
    data_d     = data_q;
    tcnt_d     = '0;
    rx_err_d   = 1'b0;
    rx_ovr_d   = 1'b0;
    case (rx_state_q)
      R_HUNT: rx_state_d = (rxValid && rxByte == RX_SYNC) ? R_CTRL : R_HUNT;
      R_HOLD: begin
        rx_ovr_d   = rxValid;
        rx_state_d = clearDR ? R_HUNT : R_HOLD;
      end
      default:
        // An arriving byte beats a timeout expiring in the same cycle.
        if (rxValid) begin
          if (rx_state_q == R_CTRL) control_d = rxByte;
          else data_d[{lane, 3'b000} +: 8] = rxByte;
          rx_state_d = (rx_state_q == R_D3) ? R_HOLD : rx_state_t'(rx_state_q + 3'd1);
        end else if (tcnt_q == T_LAST) begin
          rx_state_d = R_HUNT;
          rx_err_d   = 1'b1;
        end else tcnt_d = tcnt_q + 1'b1;
    endcase
  end
  always_comb begin
    tx_state_d = tx_state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    if (tx_state_q == T_IDLE) begin
      if (rise) begin
        tx_state_d = T_SEND;
        idx_d      = 3'd0;
        frame_d    = {outputData, status, TX_SYNC};
      end
    end else if (txReady) begin
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      tx_state_d = (idx_q == 3'd5) ? T_IDLE : T_SEND;
    end
  end
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      rx_state_q <= R_HUNT;
      tx_state_q <= T_IDLE;
      control_q  <= '0;
      data_q     <= '0;
      tcnt_q     <= '0;
      rx_err_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      idx_q      <= '0;
      frame_q    <= '0;
      trans_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      control_q  <= control_d;
      data_q     <= data_d;
      tcnt_q     <= tcnt_d;
      rx_err_q   <= rx_err_d;
      rx_ovr_q   <= rx_ovr_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      trans_q    <= transmitData;
    end
  end
  assign dataReceived = rx_state_q == R_HOLD;
  assign control      = control_q;
  assign inputData    = data_q;
  assign rxError      = rx_err_q;
  assign rxOverrun    = rx_ovr_q;
  assign txValid      = tx_state_q == T_SEND;
  assign txBusy       = tx_state_q == T_SEND;
  assign txByte       = txValid ? frame_q[{idx_q, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_sandbox_host_link.sv
// tb_sandbox_host_link: scoreboard bench for sandbox_host_link.
module tb_sandbox_host_link;
  localparam int TO = 40;
  logic        masterClock = 1'b0, reset = 1'b0;
  logic        rxValid = 1'b0, txReady = 1'b0, clearDR = 1'b0, transmitData = 1'b0;
  logic [7:0]  rxByte = 8'h00, status = 8'h00;
  logic [31:0] outputData = 32'h0;
  logic        txValid, dataReceived, txBusy, rxError, rxOverrun;
  logic [7:0]  txByte, control;
  logic [31:0] inputData;
  int vectors = 0, miscompares = 0, ovr_cnt = 0, err_cnt = 0;
  logic [39:0] rxq[$];
  logic [7:0]  txq[$];
  logic [39:0] cur = '0;
  logic        dr_prev = 1'b0;

  sandbox_host_link #(.TIMEOUT_CYCLES(TO)) dut (
    .masterClock(masterClock), .reset(reset), .rxValid(rxValid), .rxByte(rxByte),
    .txReady(txReady), .txValid(txValid), .txByte(txByte), .dataReceived(dataReceived),
    .control(control), .inputData(inputData), .clearDR(clearDR), .transmitData(transmitData),
    .status(status), .outputData(outputData), .txBusy(txBusy), .rxError(rxError),
    .rxOverrun(rxOverrun)
  );

  always #5 masterClock = ~masterClock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge masterClock) begin
    if (reset) begin
      if (rxOverrun) ovr_cnt++;
      if (rxError) err_cnt++;
      if (dataReceived && !dr_prev) begin
        chk("rx_pending", 64'(rxq.size() != 0), 64'd1);
        if (rxq.size() != 0) cur = rxq.pop_front();
      end
      if (dataReceived) begin
        chk("control", 64'(control), 64'(cur[39:32]));
        chk("inputData", 64'(inputData), 64'(cur[31:0]));
      end
      dr_prev = dataReceived;
      if (txValid) begin
        chk("tx_pending", 64'(txq.size() != 0), 64'd1);
        if (txq.size() != 0) begin
          chk("txByte", 64'(txByte), 64'(txq[0]));
          if (txReady) void'(txq.pop_front());
        end
      end
    end else dr_prev = 1'b0;
  end

  task automatic tick;
    @(posedge masterClock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxValid = 1'b1;
    rxByte  = b;
    tick;
    rxValid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] ctrl, input logic [31:0] d, input int gap, input bit expect_frame);
    logic [47:0] f;
    f = {d, ctrl, 8'hA5};
    if (expect_frame) rxq.push_back({ctrl, d});
    for (int i = 0; i < 6; i++) begin
      send_byte(f[i*8 +: 8]);
      if (i < 5) repeat (gap) tick;
    end
    if (expect_frame) chk("dr_latency", 64'(dataReceived), 64'd1);
  endtask

  task automatic clear_dr;
    clearDR = 1'b1;
    tick;
    clearDR = 1'b0;
    chk("dr_cleared", 64'(dataReceived), 64'd0);
  endtask

  task automatic push_tx(input logic [7:0] st, input logic [31:0] d);
    txq.push_back(8'h5A);
    txq.push_back(st);
    for (int i = 0; i < 4; i++) txq.push_back(d[i*8 +: 8]);
  endtask

  task automatic start_tx(input logic [7:0] st, input logic [31:0] d);
    status     = st;
    outputData = d;
    push_tx(st, d);
    transmitData = 1'b1;
    tick;
    transmitData = 1'b0;
    chk("txBusy_start", 64'(txBusy), 64'd1);
  endtask

  task automatic wait_tx_done;
    for (int n = 0; n < 300 && txBusy; n++) tick;
    chk("tx_done", 64'(txBusy), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dr"}, 64'(dataReceived), 64'd0);
    chk({tag, "_control"}, 64'(control), 64'd0);
    chk({tag, "_inputData"}, 64'(inputData), 64'd0);
    chk({tag, "_txValid"}, 64'(txValid), 64'd0);
    chk({tag, "_txByte"}, 64'(txByte), 64'd0);
    chk({tag, "_txBusy"}, 64'(txBusy), 64'd0);
    chk({tag, "_rxError"}, 64'(rxError), 64'd0);
    chk({tag, "_rxOverrun"}, 64'(rxOverrun), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    chk_all_zero("reset");
    reset = 1'b1;
    tick;
    // 1. basic receive
    send_rx(8'h01, 32'h44332211, 0, 1'b1);
    tick;
    clear_dr;
    // 2. hunt, overrun
    send_byte(8'h00);
    send_byte(8'hFF);
    send_rx(8'h03, 32'hDDCCBBAA, 1, 1'b1);
    send_byte(8'h77);
    repeat (2) tick;
    chk("overrun_count", 64'(ovr_cnt), 64'd1);
    clear_dr;
    // 3. timeout, then a frame whose bytes land exactly on the timeout cycle
    send_byte(8'hA5);
    tick;
    send_byte(8'h01);
    tick;
    send_byte(8'h11);
    repeat (TO + 5) tick;
    chk("error_count", 64'(err_cnt), 64'd1);
    chk("dr_after_timeout", 64'(dataReceived), 64'd0);
    send_rx(8'h02, 32'h87654321, TO - 1, 1'b1);
    chk("error_count_boundary", 64'(err_cnt), 64'd1);
    clear_dr;
    // 4. basic transmit
    txReady = 1'b1;
    start_tx(8'h81, 32'hDEADBEEF);
    wait_tx_done;
    // 5. backpressure, ignored second edge, mid-frame data change
    txReady = 1'b0;
    start_tx(8'h3C, 32'h01234567);
    for (int i = 0; i < 400 && txBusy; i++) begin
      txReady = 1'($urandom_range(0, 1));
      if (i == 3) transmitData = 1'b1;
      if (i == 4) transmitData = 1'b0;
      if (i == 5) begin
        outputData = 32'hFFFFFFFF;
        status     = 8'h00;
      end
      tick;
    end
    transmitData = 1'b0;
    chk("tx5_done", 64'(txBusy), 64'd0);
    txReady = 1'b1;
    repeat (10) tick;
    chk("tx5_queue", 64'(txq.size()), 64'd0);
    // 6. reset during byte 3 of both directions
    txReady = 1'b0;
    status = 8'h11;
    outputData = 32'h44332211;
    push_tx(8'h11, 32'h44332211);
    transmitData = 1'b1;
    tick;
    transmitData = 1'b0;
    txReady = 1'b1;
    rxValid = 1'b1;
    rxByte  = 8'hA5;
    tick;
    rxByte = 8'h09;
    tick;
    rxByte = 8'h55;
    reset  = 1'b0;
    tick;
    reset   = 1'b1;
    rxValid = 1'b0;
    txReady = 1'b0;
    chk_all_zero("midreset");
    txq.delete();
    tick;
    send_rx(8'h0B, 32'hCAFEF00D, 0, 1'b1);
    tick;
    clear_dr;
    txReady = 1'b1;
    start_tx(8'h22, 32'h89ABCDEF);
    wait_tx_done;
    repeat (5) tick;
    chk("final_rxq", 64'(rxq.size()), 64'd0);
    chk("final_txq", 64'(txq.size()), 64'd0);
    chk("final_overrun", 64'(ovr_cnt), 64'd1);
    chk("final_error", 64'(err_cnt), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
